// File: rtl/ir_nec_tx.sv
// NEC infrared frame transmitter.
// Accepts a 32-bit payload and sends lead mark/space, 32 pulse-distance bits
// (LSB first), a stop mark and an idle gap, with the marks modulated onto a
// square carrier. ready drops for the whole frame, and done pulses once on
// return to idle.
module ir_nec_tx #(
    parameter int TICKS_PER_UNIT = 28125,
    parameter int CARRIER_DIV    = 1316,
    parameter int GAP_UNITS      = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        valid,
    output logic        ready,
    output logic        ir_out,
    output logic        envelope,
    output logic        done
);

    localparam int TICK_W    = $clog2(TICKS_PER_UNIT);
    localparam int CAR_W     = $clog2(CARRIER_DIV);
    localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int UNIT_W    = $clog2(MAX_UNITS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [CAR_W-1:0]  CAR_LAST  = CAR_W'(CARRIER_DIV - 1);
    localparam logic [CAR_W-1:0]  CAR_HALF  = CAR_W'(CARRIER_DIV / 2);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [UNIT_W-1:0]   unit_cnt;
    logic [UNIT_W-1:0]   unit_len;
    logic [CAR_W-1:0]    carrier_cnt;
    logic [4:0]          bit_idx;
    logic [31:0]         data_q;
    logic                state_end;

    // Length of the current state in NEC units; a bit space stretches for a one.
    always_comb begin
        unit_len = UNIT_W'(1);
        case (state)
            LEAD_MARK:  unit_len = UNIT_W'(16);
            LEAD_SPACE: unit_len = UNIT_W'(8);
            BIT_SPACE:  unit_len = data_q[bit_idx] ? UNIT_W'(3) : UNIT_W'(1);
            GAP:        unit_len = UNIT_W'(GAP_UNITS);
            default:    unit_len = UNIT_W'(1);
        endcase
    end

    assign state_end = (tick_cnt == TICK_LAST) && (unit_cnt == unit_len - UNIT_W'(1));

    // State register; reset returns straight to idle and aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Frame sequencing plus the state-decoded ready/envelope/ir_out outputs.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        envelope   = 1'b0;
        ir_out     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) next_state = LEAD_MARK;
            end
            LEAD_MARK: begin
                envelope = 1'b1;
                if (state_end) next_state = LEAD_SPACE;
            end
            LEAD_SPACE: begin
                if (state_end) next_state = BIT_MARK;
            end
            BIT_MARK: begin
                envelope = 1'b1;
                if (state_end) next_state = BIT_SPACE;
            end
            BIT_SPACE: begin
                if (state_end) next_state = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
            end
            STOP_MARK: begin
                envelope = 1'b1;
                if (state_end) next_state = GAP;
            end
            GAP: begin
                if (state_end) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        ir_out = envelope && (carrier_cnt < CAR_HALF);
    end

    // Tick/unit timers, bit index and payload latch; timers clear on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            unit_cnt <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            unit_cnt <= '0;
            bit_idx  <= '0;
            if (valid) data_q <= data;
        end else if (state_end) begin
            tick_cnt <= '0;
            unit_cnt <= '0;
            if (state == BIT_SPACE) bit_idx <= bit_idx + 5'd1;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            unit_cnt <= unit_cnt + UNIT_W'(1);
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Carrier phase counter, held at zero outside marks so each mark starts high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carrier_cnt <= '0;
        end else if (envelope && !state_end) begin
            carrier_cnt <= (carrier_cnt == CAR_LAST) ? '0 : carrier_cnt + CAR_W'(1);
        end else begin
            carrier_cnt <= '0;
        end
    end

    // done fires in the first idle cycle after the gap expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == GAP) && state_end;
        end
    end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed testbench for ir_nec_tx with short timing parameters.
module tb_ir_nec_tx;

    localparam int TPU  = 10;
    localparam int CDIV = 4;
    localparam int GAPU = 72;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] data  = '0;
    logic        ready;
    logic        ir_out;
    logic        envelope;
    logic        done;

    int total  = 0;
    int passed = 0;

    int done_at;
    int env_errs;
    int ir_errs;
    int rdy_errs;
    int done_errs;
    bit env_hist [0:2400];
    bit ir_hist  [0:2400];

    ir_nec_tx #(
        .TICKS_PER_UNIT(TPU),
        .CARRIER_DIV   (CDIV),
        .GAP_UNITS     (GAPU)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .ir_out  (ir_out),
        .envelope(envelope),
        .done    (done)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Offer a payload at the negedge; the following posedge is acceptance (cycle 0).
    task automatic launch(input logic [31:0] d);
        @(negedge clk);
        data  = d;
        valid = 1'b1;
        @(posedge clk);
    endtask

    // Watch cycles 1..stop_at against a segment model built from the frame format.
    task automatic monitor(input logic [31:0] d, input bit hold, input logic [31:0] nd,
                           input int exp_done, input int stop_at);
        int seg_len[$];
        bit seg_mark[$];
        int si;
        int off;
        bit e_env;
        bit e_ir;
        seg_len.push_back(16 * TPU); seg_mark.push_back(1'b1);
        seg_len.push_back(8 * TPU);  seg_mark.push_back(1'b0);
        for (int i = 0; i < 32; i++) begin
            seg_len.push_back(TPU); seg_mark.push_back(1'b1);
            seg_len.push_back(d[i] ? 3 * TPU : TPU); seg_mark.push_back(1'b0);
        end
        seg_len.push_back(TPU); seg_mark.push_back(1'b1);
        seg_len.push_back(GAPU * TPU); seg_mark.push_back(1'b0);
        done_at = 0; env_errs = 0; ir_errs = 0; rdy_errs = 0; done_errs = 0;
        si = 0; off = 0;
        env_hist[0] = 1'b0; ir_hist[0] = 1'b0;
        for (int c = 1; c <= stop_at; c++) begin
            @(negedge clk);
            if (si < seg_len.size()) begin
                e_env = seg_mark[si];
                e_ir  = e_env && ((off % CDIV) < (CDIV / 2));
            end else begin
                e_env = 1'b0;
                e_ir  = 1'b0;
            end
            env_hist[c] = envelope;
            ir_hist[c]  = ir_out;
            if (envelope !== e_env) env_errs++;
            if (ir_out !== e_ir) ir_errs++;
            if (ready !== (c == exp_done)) rdy_errs++;
            if (done !== (c == exp_done)) done_errs++;
            if (done === 1'b1 && done_at == 0) done_at = c;
            if (si < seg_len.size()) begin
                off++;
                if (off == seg_len[si]) begin
                    si++;
                    off = 0;
                end
            end
            valid = hold;
            data  = (hold && c == exp_done) ? nd : $urandom;
        end
    endtask

    // Reset holds the idle outputs regardless of clock activity or valid.
    task automatic test_reset();
        #3;
        total++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b, expected 1", ready); else passed++;
        total++; if (ir_out !== 1'b0) $display("[TB] FAIL reset_ir_out: got %b, expected 0", ir_out); else passed++;
        total++; if (envelope !== 1'b0) $display("[TB] FAIL reset_envelope: got %b, expected 0", envelope); else passed++;
        total++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b, expected 0", done); else passed++;
        valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (envelope !== 1'b0 || ready !== 1'b1) $display("[TB] FAIL reset_hold: got env=%b ready=%b, expected env=0 ready=1", envelope, ready); else passed++;
        rst   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
    endtask

    // Payload 0x00FF00FF: lead timing, first bit timing, carrier shape, done cycle.
    task automatic test_frame_ff();
        logic [3:0] pat;
        int pulses;
        launch(32'h00FF00FF);
        monitor(32'h00FF00FF, 1'b0, 32'h0, 1931, 1931);
        total++; if (done_at !== 1931) $display("[TB] FAIL ff_done_cycle: got %0d, expected 1931", done_at); else passed++;
        total++; if (env_errs !== 0) $display("[TB] FAIL ff_envelope: got %0d bad cycles, expected 0", env_errs); else passed++;
        total++; if (ir_errs !== 0) $display("[TB] FAIL ff_ir_out: got %0d bad cycles, expected 0", ir_errs); else passed++;
        total++; if (rdy_errs !== 0) $display("[TB] FAIL ff_ready: got %0d bad cycles, expected 0", rdy_errs); else passed++;
        total++; if (done_errs !== 0) $display("[TB] FAIL ff_done_pulse: got %0d bad cycles, expected 0", done_errs); else passed++;
        total++; if (env_hist[1] !== 1'b1 || env_hist[160] !== 1'b1 || env_hist[161] !== 1'b0)
            $display("[TB] FAIL ff_lead_edges: got c1=%b c160=%b c161=%b, expected 1 1 0", env_hist[1], env_hist[160], env_hist[161]); else passed++;
        total++; if (env_hist[240] !== 1'b0 || env_hist[241] !== 1'b1 || env_hist[250] !== 1'b1 || env_hist[251] !== 1'b0)
            $display("[TB] FAIL ff_bit0_mark: got c240=%b c241=%b c250=%b c251=%b, expected 0 1 1 0", env_hist[240], env_hist[241], env_hist[250], env_hist[251]); else passed++;
        total++; if (env_hist[280] !== 1'b0 || env_hist[281] !== 1'b1)
            $display("[TB] FAIL ff_bit0_space: got c280=%b c281=%b, expected 0 1", env_hist[280], env_hist[281]); else passed++;
        pat = {ir_hist[1], ir_hist[2], ir_hist[3], ir_hist[4]};
        total++; if (pat !== 4'b1100) $display("[TB] FAIL ff_carrier_lead: got %b, expected 1100", pat); else passed++;
        pat = {ir_hist[241], ir_hist[242], ir_hist[243], ir_hist[244]};
        total++; if (pat !== 4'b1100) $display("[TB] FAIL ff_carrier_bit0: got %b, expected 1100", pat); else passed++;
        pulses = 0;
        for (int c = 1; c <= 160; c++) if (ir_hist[c] && !ir_hist[c-1]) pulses++;
        total++; if (pulses !== 40) $display("[TB] FAIL ff_lead_pulses: got %0d, expected 40", pulses); else passed++;
        @(negedge clk);
    endtask

    // All-zero and all-one payloads bound the frame length.
    task automatic test_extremes();
        launch(32'h00000000);
        monitor(32'h00000000, 1'b0, 32'h0, 1611, 1611);
        total++; if (done_at !== 1611) $display("[TB] FAIL zero_done_cycle: got %0d, expected 1611", done_at); else passed++;
        total++; if (env_errs + ir_errs + rdy_errs + done_errs !== 0)
            $display("[TB] FAIL zero_frame: got env=%0d ir=%0d rdy=%0d done=%0d bad cycles, expected 0", env_errs, ir_errs, rdy_errs, done_errs); else passed++;
        @(negedge clk);
        launch(32'hFFFFFFFF);
        monitor(32'hFFFFFFFF, 1'b0, 32'h0, 2251, 2251);
        total++; if (done_at !== 2251) $display("[TB] FAIL ones_done_cycle: got %0d, expected 2251", done_at); else passed++;
        total++; if (env_errs + ir_errs + rdy_errs + done_errs !== 0)
            $display("[TB] FAIL ones_frame: got env=%0d ir=%0d rdy=%0d done=%0d bad cycles, expected 0", env_errs, ir_errs, rdy_errs, done_errs); else passed++;
        @(negedge clk);
    endtask

    // valid held high with churning data; the next payload is taken on the done cycle.
    task automatic test_back_to_back();
        launch(32'h12345678);
        monitor(32'h12345678, 1'b1, 32'h0000000F, 1871, 1871);
        total++; if (done_at !== 1871) $display("[TB] FAIL b2b_first_done: got %0d, expected 1871", done_at); else passed++;
        total++; if (env_errs + ir_errs + rdy_errs + done_errs !== 0)
            $display("[TB] FAIL b2b_first_frame: got env=%0d ir=%0d rdy=%0d done=%0d bad cycles, expected 0", env_errs, ir_errs, rdy_errs, done_errs); else passed++;
        @(posedge clk);
        monitor(32'h0000000F, 1'b0, 32'h0, 1691, 1691);
        total++; if (done_at !== 1691) $display("[TB] FAIL b2b_second_done: got %0d, expected 1691", done_at); else passed++;
        total++; if (env_errs + ir_errs + rdy_errs + done_errs !== 0)
            $display("[TB] FAIL b2b_second_frame: got env=%0d ir=%0d rdy=%0d done=%0d bad cycles, expected 0", env_errs, ir_errs, rdy_errs, done_errs); else passed++;
        @(negedge clk);
    endtask

    // Reset during a modulated mark kills outputs at once; the next frame is clean.
    task automatic test_mid_reset();
        int done_seen;
        launch(32'h00FF00FF);
        monitor(32'h00FF00FF, 1'b0, 32'h0, 1931, 481);
        total++; if (env_errs + ir_errs !== 0 || ir_out !== 1'b1)
            $display("[TB] FAIL abort_prefix: got env=%0d ir=%0d bad cycles ir_out=%b, expected 0 0 1", env_errs, ir_errs, ir_out); else passed++;
        rst = 1'b1;
        #1;
        total++; if (ir_out !== 1'b0 || envelope !== 1'b0)
            $display("[TB] FAIL abort_outputs: got ir_out=%b env=%b, expected 0 0", ir_out, envelope); else passed++;
        total++; if (ready !== 1'b1 || done !== 1'b0)
            $display("[TB] FAIL abort_ready_done: got ready=%b done=%b, expected 1 0", ready, done); else passed++;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        total++; if (done_seen !== 0) $display("[TB] FAIL abort_no_done: got %0d done cycles, expected 0", done_seen); else passed++;
        launch(32'h0000FFFF);
        monitor(32'h0000FFFF, 1'b0, 32'h0, 1931, 1931);
        total++; if (done_at !== 1931) $display("[TB] FAIL after_reset_done: got %0d, expected 1931", done_at); else passed++;
        total++; if (env_errs + ir_errs + rdy_errs + done_errs !== 0)
            $display("[TB] FAIL after_reset_frame: got env=%0d ir=%0d rdy=%0d done=%0d bad cycles, expected 0", env_errs, ir_errs, rdy_errs, done_errs); else passed++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_frame_ff();
        test_extremes();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
